// File: rtl/trng_fetch_if.sv
// -----------------------------------------------------------------------------
// trng_fetch_if
// Groups the two handshakes of the TRNG fetch controller:
//   - trng_request / trng_ready / trng_data : four-phase link to the entropy source
//   - rnd_valid / rnd_ready / rnd_data      : valid/ready stream to crypto consumers
// modport master : the fetch controller (drives request, serves the stream)
// modport slave  : the environment (entropy source plus consumer)
// -----------------------------------------------------------------------------
interface trng_fetch_if;
  logic        trng_request;
  logic        trng_ready;
  logic [31:0] trng_data;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [31:0] rnd_data;

  modport master (
    output trng_request,
    input  trng_ready,
    input  trng_data,
    output rnd_valid,
    input  rnd_ready,
    output rnd_data
  );

  modport slave (
    input  trng_request,
    output trng_ready,
    output trng_data,
    input  rnd_valid,
    output rnd_ready,
    input  rnd_data
  );
endinterface

// File: rtl/trng_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// trng_fetch_ctrl
// Initiator of the TRNG four-phase handshake. Each word is requested, captured,
// screened by a repetition health test and pushed into a small first-word-fall-
// through FIFO that feeds crypto consumers over a valid/ready stream. A source
// that does not answer within TIMEOUT cycles is abandoned and flagged.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus            trng_fetch_if.master (source handshake + consumer stream)
//   i_enable       keep fetching words while high
//   i_err_clear    one-cycle pulse: clear sticky errors and repetition history
//   o_level        FIFO occupancy, 0..DEPTH
//   o_health_fail  sticky, REP_LIMIT identical words captured in a row
//   o_timeout_err  sticky, source failed to answer within TIMEOUT cycles
// -----------------------------------------------------------------------------
module trng_fetch_ctrl #(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 64,
  parameter int REP_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  trng_fetch_if.master             bus,
  input  logic                     i_enable,
  input  logic                     i_err_clear,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_health_fail,
  output logic                     o_timeout_err
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int RW     = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RELEASE} state_t;

  state_t              r_state, w_state_nxt;
  logic                w_capture, w_abort, w_push, w_pop, w_valid, w_dup, w_rep_trip;
  logic                r_req;
  logic [TW-1:0]       r_tcnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic [DATA_W-1:0]   r_last_word;
  logic                r_last_valid;
  logic [RW-1:0]       r_rep_cnt;
  logic                r_health_fail, r_timeout_err;

  // ---- handshake FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE:
        if (i_enable && !r_health_fail && (r_level < LW'(DEPTH)))
          w_state_nxt = S_REQ;
      S_REQ:
        if (bus.trng_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RELEASE;
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = S_RELEASE;
        end
      // Re-requesting before ready falls would capture the source's stale word.
      S_RELEASE:
        if (!bus.trng_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request is a flop copy of "next state is REQ" so it rises the edge after
  // the IDLE decision and falls on the capture/abort edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req  <= 1'b0;
      r_tcnt <= '0;
    end else begin
      r_req  <= (w_state_nxt == S_REQ);
      r_tcnt <= (r_state == S_REQ) ? r_tcnt + TW'(1) : '0;
    end
  end

  // ---- repetition health test ----
  assign w_dup      = r_last_valid && (bus.trng_data == r_last_word);
  assign w_push     = w_capture && !w_dup;
  assign w_rep_trip = w_capture && w_dup && ((r_rep_cnt + RW'(1)) == RW'(REP_LIMIT - 1));

  // Capture updates are written after the clear so a coincident event wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_valid  <= 1'b0;
      r_rep_cnt     <= '0;
      r_health_fail <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (i_err_clear) begin
        r_last_valid <= 1'b0;
        r_rep_cnt    <= '0;
      end
      if (w_push) begin
        r_last_valid <= 1'b1;
        r_rep_cnt    <= '0;
      end else if (w_capture && w_dup) begin
        r_rep_cnt    <= r_rep_cnt + RW'(1);
      end
      if (w_rep_trip)       r_health_fail <= 1'b1;
      else if (i_err_clear) r_health_fail <= 1'b0;
      if (w_abort)          r_timeout_err <= 1'b1;
      else if (i_err_clear) r_timeout_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_last_word <= bus.trng_data;
  end

  // ---- output FIFO ----
  // Only one request is ever in flight, so a push never meets a full FIFO.
  assign w_valid = (r_level != '0);
  assign w_pop   = w_valid && bus.rnd_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.trng_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.trng_request = r_req;
  assign bus.rnd_valid    = w_valid;
  // Masked to zero while empty so the data output is deterministic out of reset.
  assign bus.rnd_data     = w_valid ? r_mem[r_rd_ptr] : '0;
  assign o_level          = r_level;
  assign o_health_fail    = r_health_fail;
  assign o_timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_trng_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trng_fetch_ctrl
// Drives trng_fetch_ctrl with a cycle-stepped entropy-source model and a
// consumer. Every word the source hands over goes through a reference
// repetition rule; accepted words are queued as the expected stream, and a
// monitor compares the DUT's stream, occupancy and error flags each cycle.
// -----------------------------------------------------------------------------
module tb_trng_fetch_ctrl;
  localparam int DEPTH     = 4;
  localparam int TIMEOUT   = 64;
  localparam int REP_LIMIT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic err_clear = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic health_fail, timeout_err;

  trng_fetch_if bus();

  trng_fetch_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .REP_LIMIT(REP_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .i_enable(enable), .i_err_clear(err_clear),
    .o_level(level), .o_health_fail(health_fail), .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] exp_q[$];
  logic [31:0] m_last = '0;
  bit          m_lv = 1'b0;
  int          m_rc = 0;
  bit          m_hf = 1'b0;
  bit          m_te = 1'b0;

  // source model knobs
  typedef enum {PH_WAIT, PH_DELAY, PH_DELIVER, PH_HOLD, PH_MUTE} ph_t;
  ph_t         ph = PH_WAIT;
  logic [31:0] src_q[$];
  int          src_delay = 2;
  int          src_hold = 0;
  bit          src_mute = 1'b0;
  bit          src_rand = 1'b0;
  int          rises = 0;
  logic [31:0] alpha [4] = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // A word is kept unless it repeats the last kept word; REP_LIMIT identical
  // words in a row (the kept one plus REP_LIMIT-1 repeats) flag health failure.
  function automatic void model_capture(input logic [31:0] w);
    if (!m_lv || w != m_last) begin
      exp_q.push_back(w);
      m_last = w;
      m_lv   = 1'b1;
      m_rc   = 0;
    end else begin
      m_rc++;
      if (m_rc >= REP_LIMIT - 1) m_hf = 1'b1;
    end
  endfunction

  function automatic logic [31:0] next_word();
    if (src_q.size() != 0) return src_q.pop_front();
    if (src_rand) return alpha[$urandom_range(0, 3)];
    return $urandom();
  endfunction

  // Entropy source: answers each request after src_delay cycles, keeps ready
  // high src_hold cycles past the request drop, or stays silent when muted.
  initial begin : source
    int dcnt, hcnt, mk;
    bit prev;
    dcnt = 0; hcnt = 0; mk = 0; prev = 1'b0;
    bus.trng_ready = 1'b0;
    bus.trng_data  = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        bus.trng_ready = 1'b0;
        ph   = PH_WAIT;
        prev = 1'b0;
        continue;
      end
      #1;
      if (!rst_n) continue;
      if (bus.trng_request && !prev) rises++;
      prev = bus.trng_request;
      case (ph)
        PH_WAIT:
          if (bus.trng_request) begin
            if (src_rand) begin
              src_delay = $urandom_range(0, 4);
              src_hold  = $urandom_range(0, 3);
            end
            if (src_mute) begin
              mk = 0;
              ph = PH_MUTE;
            end else if (src_delay == 0) begin
              bus.trng_data  = next_word();
              bus.trng_ready = 1'b1;
              ph = PH_DELIVER;
            end else begin
              dcnt = src_delay;
              ph = PH_DELAY;
            end
          end
        PH_DELAY: begin
          dcnt--;
          if (dcnt == 0) begin
            bus.trng_data  = next_word();
            bus.trng_ready = 1'b1;
            ph = PH_DELIVER;
          end
        end
        PH_DELIVER: begin
          model_capture(bus.trng_data);
          check("req_drop_on_capture", 32'(bus.trng_request), 0);
          if (src_hold == 0) begin
            bus.trng_ready = 1'b0;
            ph = PH_WAIT;
          end else begin
            hcnt = src_hold;
            ph = PH_HOLD;
          end
        end
        PH_HOLD: begin
          check("no_rerequest_while_ready", 32'(bus.trng_request), 0);
          hcnt--;
          if (hcnt == 0) begin
            bus.trng_ready = 1'b0;
            ph = PH_WAIT;
          end
        end
        PH_MUTE: begin
          mk++;
          if (mk == TIMEOUT - 1) begin
            check("req_held_before_timeout", 32'(bus.trng_request), 1);
            check("timeout_err_before_limit", 32'(timeout_err), 0);
          end
          if (mk == TIMEOUT) begin
            check("req_drop_on_timeout", 32'(bus.trng_request), 0);
            check("timeout_err_at_limit", 32'(timeout_err), 1);
            m_te     = 1'b1;
            src_mute = 1'b0;
            ph = PH_WAIT;
          end
        end
        default: ph = PH_WAIT;
      endcase
    end
  end

  // Monitor: occupancy, flags and popped words against the reference model.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("level", 32'(level), 32'(exp_q.size()));
        check("rnd_valid", 32'(bus.rnd_valid), 32'(exp_q.size() != 0));
        check("health_fail", 32'(health_fail), 32'(m_hf));
        check("timeout_err", 32'(timeout_err), 32'(m_te));
        if (bus.rnd_valid && bus.rnd_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pop_unexpected: got %h, expected no word", bus.rnd_data);
          end else begin
            check("rnd_data", bus.rnd_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation did not complete");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input int n, input int budget);
    int c = 0;
    while (int'(level) != n && c < budget) begin tick(); c++; end
    check($sformatf("wait_level_%0d", n), 32'(level), 32'(n));
  endtask

  task automatic wait_rises(input int n, input int budget);
    int c = 0;
    while (rises < n && c < budget) begin tick(); c++; end
    check($sformatf("wait_rises_%0d", n), 32'(rises), 32'(n));
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    int quiet = 0;
    while (quiet < 3 && c < budget) begin
      tick(); c++;
      if (ph == PH_WAIT && !bus.trng_request && !bus.trng_ready) quiet++;
      else quiet = 0;
    end
    check("wait_idle", 32'(quiet >= 3), 1);
  endtask

  task automatic drain();
    int c = 0;
    enable = 1'b0;
    wait_idle(400);
    bus.rnd_ready = 1'b1;
    while (bus.rnd_valid && c < 100) begin tick(); c++; end
    bus.rnd_ready = 1'b0;
    check("drain_empty", 32'(level), 0);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(posedge clk);
    m_hf = 1'b0; m_te = 1'b0; m_lv = 1'b0; m_rc = 0;
    #1;
    err_clear = 1'b0;
  endtask

  initial begin : main
    int r0;
    bus.rnd_ready = 1'b0;
    tick(3);
    check("rst_request", 32'(bus.trng_request), 0);
    check("rst_rnd_valid", 32'(bus.rnd_valid), 0);
    check("rst_rnd_data", bus.rnd_data, 0);
    check("rst_level", 32'(level), 0);
    check("rst_health_fail", 32'(health_fail), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    rst_n = 1'b1;
    tick(2);

    // two known words with a slow source, held in the FIFO then drained in order
    src_delay = 33;
    src_q.push_back(32'hA5A5_0001);
    src_q.push_back(32'hA5A5_0002);
    enable = 1'b1;
    wait_rises(2, 200);
    enable = 1'b0;
    wait_idle(200);
    check("t1_level_peak", 32'(level), 2);
    check("t1_two_requests", 32'(rises), 2);
    drain();

    // fill to DEPTH, then one pop buys exactly one new request
    src_delay = 2;
    r0 = rises;
    enable = 1'b1;
    wait_level(DEPTH, 200);
    tick(20);
    check("t2_requests_to_full", 32'(rises - r0), 32'(DEPTH));
    check("t2_req_low_when_full", 32'(bus.trng_request), 0);
    bus.rnd_ready = 1'b1;
    tick();
    bus.rnd_ready = 1'b0;
    wait_rises(r0 + DEPTH + 1, 50);
    wait_level(DEPTH, 50);
    tick(20);
    check("t2_one_refill", 32'(rises - r0), 32'(DEPTH + 1));
    drain();

    // repetition test trips on the third identical word
    src_delay = 1;
    repeat (3) src_q.push_back(32'h1234_5678);
    src_q.push_back(32'h9ABC_DEF0);
    r0 = rises;
    enable = 1'b1;
    begin
      int c = 0;
      while (!health_fail && c < 200) begin tick(); c++; end
    end
    check("t3_health_fail", 32'(health_fail), 1);
    wait_idle(100);
    tick(20);
    check("t3_three_requests", 32'(rises - r0), 3);
    check("t3_one_push", 32'(level), 1);
    check("t3_blocked", 32'(bus.trng_request), 0);
    src_q.delete();
    src_q.push_back(32'h1234_5678);
    pulse_clear();
    wait_level(2, 100);
    check("t3_resumed", 32'(rises - r0), 4);
    drain();

    // silent source: timeout, then a responsive retry delivers a word
    src_delay = 1;
    src_mute = 1'b1;
    r0 = rises;
    enable = 1'b1;
    wait_rises(r0 + 2, 200);
    wait_level(1, 50);
    check("t4_mute_consumed", 32'(src_mute), 0);
    drain();
    pulse_clear();

    // source keeps ready high after the request drops
    src_hold = 5;
    src_delay = 1;
    r0 = rises;
    enable = 1'b1;
    wait_rises(r0 + 2, 200);
    enable = 1'b0;
    wait_idle(200);
    check("t5_two_words", 32'(level), 2);
    check("t5_two_requests", 32'(rises - r0), 2);
    drain();
    src_hold = 0;

    // reset in the middle of a request with two words buffered
    src_delay = 20;
    r0 = rises;
    enable = 1'b1;
    wait_level(2, 200);
    wait_rises(r0 + 3, 50);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_request", 32'(bus.trng_request), 0);
    check("mid_rst_rnd_valid", 32'(bus.rnd_valid), 0);
    check("mid_rst_rnd_data", bus.rnd_data, 0);
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_health_fail", 32'(health_fail), 0);
    check("mid_rst_timeout_err", 32'(timeout_err), 0);
    exp_q.delete();
    m_lv = 1'b0; m_rc = 0; m_hf = 1'b0; m_te = 1'b0;
    tick(2);
    rst_n = 1'b1;
    src_delay = 2;
    wait_level(1, 100);
    drain();

    // random source timing, small word alphabet, random consumer back-pressure
    src_rand = 1'b1;
    enable = 1'b1;
    repeat (800) begin
      bus.rnd_ready = 1'($urandom_range(0, 1));
      tick();
      if (m_hf && ph == PH_WAIT && !bus.trng_request) pulse_clear();
    end
    bus.rnd_ready = 1'b0;
    src_rand = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
